// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the 8-bit CPU sequencer: register indices, write-op
// and input-mux codes, ALU ops, FSM states and decoded instruction classes.
package cpu_sequencer_pkg;

  localparam logic [4:0] REG_B    = 5'd0;
  localparam logic [4:0] REG_C    = 5'd1;
  localparam logic [4:0] REG_D    = 5'd2;
  localparam logic [4:0] REG_E    = 5'd3;
  localparam logic [4:0] REG_H    = 5'd4;
  localparam logic [4:0] REG_L    = 5'd5;
  localparam logic [4:0] REG_F    = 5'd6;
  localparam logic [4:0] REG_A    = 5'd7;
  localparam logic [4:0] REG_PCH  = 5'd16;
  localparam logic [4:0] REG_PCL  = 5'd17;
  localparam logic [4:0] REG_NULL = 5'd30;
  localparam logic [4:0] REG_ONE  = 5'd31;

  // r-field value that selects (HL) rather than a register
  localparam logic [2:0] R_MEM = 3'b110;

  typedef enum logic [1:0] {
    WOP_IDLE  = 2'b00,
    WOP_WRITE = 2'b01,
    WOP_EX    = 2'b10,
    WOP_LOAD  = 2'b11
  } wop_e;

  typedef enum logic [1:0] {
    SEL_MEM = 2'b00,
    SEL_REG = 2'b01,
    SEL_ALU = 2'b10
  } insel_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_ADC = 3'd1,
    ALU_SUB = 3'd2,
    ALU_SBC = 3'd3,
    ALU_AND = 3'd4,
    ALU_XOR = 3'd5,
    ALU_OR  = 3'd6,
    ALU_CP  = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_RST     = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_OPERAND = 3'd3,
    ST_EXEC    = 3'd4,
    ST_HALT    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CL_NOP   = 3'd0,
    CL_HALT  = 3'd1,
    CL_LD_RR = 3'd2,
    CL_LD_RN = 3'd3,
    CL_ALU   = 3'd4
  } op_class_e;

  function automatic logic [4:0] reg_idx(input logic [2:0] r);
    return {2'b00, r};
  endfunction

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decoder: classifies the opcode and extracts the
// destination/source register indices and ALU operation.
module cpu_decode
  import cpu_sequencer_pkg::*;
(
  input  logic [7:0] i_ir,
  output op_class_e  o_class,
  output logic [4:0] o_dst,
  output logic [4:0] o_src,
  output logic [2:0] o_alu_op,
  output logic       o_illegal
);

  always_comb begin
    o_class   = CL_NOP;
    o_dst     = reg_idx(i_ir[5:3]);
    o_src     = reg_idx(i_ir[2:0]);
    o_alu_op  = i_ir[5:3];
    o_illegal = 1'b0;
    case (i_ir[7:6])
      2'b00: begin
        if (i_ir == 8'h00)
          o_class = CL_NOP;
        else if (i_ir[2:0] == R_MEM && i_ir[5:3] != R_MEM)
          o_class = CL_LD_RN;
        else
          o_illegal = 1'b1;
      end
      2'b01: begin
        // 0x76 sits where LD (HL),(HL) would be
        if (i_ir == 8'h76)
          o_class = CL_HALT;
        else if (i_ir[5:3] != R_MEM && i_ir[2:0] != R_MEM)
          o_class = CL_LD_RR;
        else
          o_illegal = 1'b1;
      end
      2'b10: begin
        if (i_ir[2:0] != R_MEM)
          o_class = CL_ALU;
        else
          o_illegal = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the 8-bit CPU core. Outputs are a
// combinational decode of the FSM state and the instruction register.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter logic [7:0] ALU_FLAGS_WE = 8'hD7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] reg_pc,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ready,
  input  logic [7:0]  mem_rdata,
  output logic [4:0]  reg_read_1,
  output logic [4:0]  reg_read_2,
  output logic [4:0]  reg_write,
  output logic [1:0]  reg_write_op,
  output logic [7:0]  reg_flags_write_en,
  output logic        reg_pc_inc,
  output logic [1:0]  reg_in_sel,
  output logic [2:0]  alu_op,
  output logic        halted,
  output logic        illegal_op
);

  state_e     r_state;
  state_e     w_next;
  logic [7:0] r_ir;

  op_class_e  w_class;
  logic [4:0] w_dst;
  logic [4:0] w_src;
  logic [2:0] w_alu_op;
  logic       w_illegal;

  cpu_decode u_decode (
    .i_ir      (r_ir),
    .o_class   (w_class),
    .o_dst     (w_dst),
    .o_src     (w_src),
    .o_alu_op  (w_alu_op),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RST;
      r_ir    <= 8'h00;
    end else begin
      r_state <= w_next;
      if (r_state == ST_FETCH && mem_ready)
        r_ir <= mem_rdata;
    end
  end

  assign mem_addr = reg_pc;

  always_comb begin
    w_next             = r_state;
    mem_rd             = 1'b0;
    reg_read_1         = REG_NULL;
    reg_read_2         = REG_NULL;
    reg_write          = REG_NULL;
    reg_write_op       = WOP_IDLE;
    reg_flags_write_en = 8'h00;
    reg_pc_inc         = 1'b0;
    reg_in_sel         = SEL_MEM;
    alu_op             = 3'd0;
    halted             = 1'b0;
    illegal_op         = 1'b0;
    case (r_state)
      ST_RST: w_next = ST_FETCH;
      ST_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          reg_pc_inc = 1'b1;
          w_next     = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // illegal opcodes decode as CL_NOP and simply refetch
        illegal_op = w_illegal;
        case (w_class)
          CL_HALT:         w_next = ST_HALT;
          CL_LD_RR, CL_ALU: w_next = ST_EXEC;
          CL_LD_RN:        w_next = ST_OPERAND;
          default:         w_next = ST_FETCH;
        endcase
      end
      ST_OPERAND: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          reg_write    = w_dst;
          reg_write_op = WOP_WRITE;
          reg_in_sel   = SEL_MEM;
          reg_pc_inc   = 1'b1;
          w_next       = ST_FETCH;
        end
      end
      ST_EXEC: begin
        w_next = ST_FETCH;
        if (w_class == CL_LD_RR) begin
          reg_read_1   = w_src;
          reg_in_sel   = SEL_REG;
          reg_write    = w_dst;
          reg_write_op = WOP_WRITE;
        end else if (w_class == CL_ALU) begin
          reg_read_1         = REG_A;
          reg_read_2         = w_src;
          alu_op             = w_alu_op;
          reg_in_sel         = SEL_ALU;
          reg_flags_write_en = ALU_FLAGS_WE;
          reg_write          = REG_A;
          reg_write_op       = (w_alu_op == ALU_CP) ? WOP_IDLE : WOP_WRITE;
        end
      end
      ST_HALT: halted = 1'b1;
      default: w_next = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a small PC/memory model around it.
module tb_cpu_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] reg_pc;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ready;
  logic [7:0]  mem_rdata;
  logic [4:0]  reg_read_1;
  logic [4:0]  reg_read_2;
  logic [4:0]  reg_write;
  logic [1:0]  reg_write_op;
  logic [7:0]  reg_flags_write_en;
  logic        reg_pc_inc;
  logic [1:0]  reg_in_sel;
  logic [2:0]  alu_op;
  logic        halted;
  logic        illegal_op;

  logic [7:0]  mem [0:15];
  int          n_cmp;
  int          n_bad;

  cpu_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .reg_pc             (reg_pc),
    .mem_addr           (mem_addr),
    .mem_rd             (mem_rd),
    .mem_ready          (mem_ready),
    .mem_rdata          (mem_rdata),
    .reg_read_1         (reg_read_1),
    .reg_read_2         (reg_read_2),
    .reg_write          (reg_write),
    .reg_write_op       (reg_write_op),
    .reg_flags_write_en (reg_flags_write_en),
    .reg_pc_inc         (reg_pc_inc),
    .reg_in_sel         (reg_in_sel),
    .alu_op             (alu_op),
    .halted             (halted),
    .illegal_op         (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register-file PC model
  always @(posedge clk or negedge reset) begin
    if (!reset)          reg_pc <= 16'h0000;
    else if (reg_pc_inc) reg_pc <= reg_pc + 16'h0001;
  end

  assign mem_rdata = mem[reg_pc[3:0]];

  // Advance one cycle; ready is applied for the new cycle before sampling.
  task automatic cyc(input logic rdy);
    @(posedge clk);
    #1 mem_ready = rdy;
    #1;
  endtask

  // Load a two-byte program, pulse reset, and leave the DUT in its RST cycle.
  task automatic restart(input logic [7:0] b0, input logic [7:0] b1);
    reset     = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = b0;
    mem[1] = b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #3;
    n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL rst_mem_rd: got %0h want 0", mem_rd); end
    n_cmp++; if (reg_write_op !== 2'b00) begin n_bad++; $display("FAIL rst_wop: got %0h want 0", reg_write_op); end
    n_cmp++; if (reg_write !== 5'd30) begin n_bad++; $display("FAIL rst_wsel: got %0d want 30", reg_write); end
    n_cmp++; if (reg_read_1 !== 5'd30 || reg_read_2 !== 5'd30) begin n_bad++; $display("FAIL rst_rsel: got %0d/%0d want 30/30", reg_read_1, reg_read_2); end
    n_cmp++; if ({halted, illegal_op, reg_pc_inc} !== 3'b000) begin n_bad++; $display("FAIL rst_strobes: got %b want 000", {halted, illegal_op, reg_pc_inc}); end
    restart(8'h00, 8'h00);
    n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL nop_rst_cycle_rd: got %0h want 0", mem_rd); end
    cyc(1'b1);
    n_cmp++; if (mem_rd !== 1'b1 || reg_pc_inc !== 1'b1) begin n_bad++; $display("FAIL nop_fetch1: got rd=%0h inc=%0h want 1/1", mem_rd, reg_pc_inc); end
    n_cmp++; if (mem_addr !== 16'h0000) begin n_bad++; $display("FAIL nop_addr: got %0h want 0", mem_addr); end
    cyc(1'b1);
    n_cmp++; if (mem_rd !== 1'b0 || reg_pc_inc !== 1'b0 || reg_write_op !== 2'b00) begin n_bad++; $display("FAIL nop_decode: got rd=%0h inc=%0h wop=%0h want 0/0/0", mem_rd, reg_pc_inc, reg_write_op); end
    n_cmp++; if (reg_pc !== 16'h0001) begin n_bad++; $display("FAIL nop_pc: got %0h want 1", reg_pc); end
    cyc(1'b1);
    n_cmp++; if (mem_rd !== 1'b1 || reg_pc_inc !== 1'b1 || reg_write_op !== 2'b00) begin n_bad++; $display("FAIL nop_fetch2: got rd=%0h inc=%0h wop=%0h want 1/1/0", mem_rd, reg_pc_inc, reg_write_op); end
    n_cmp++; if (mem_addr !== 16'h0001) begin n_bad++; $display("FAIL nop_addr2: got %0h want 1", mem_addr); end
  endtask

  task automatic test_ld_imm;
    restart(8'h3E, 8'h5A);
    cyc(1'b1);
    cyc(1'b1);
    n_cmp++; if (reg_write_op !== 2'b00) begin n_bad++; $display("FAIL ldn_decode_wop: got %0h want 0", reg_write_op); end
    cyc(1'b1);
    n_cmp++; if (mem_rd !== 1'b1 || reg_pc_inc !== 1'b1) begin n_bad++; $display("FAIL ldn_operand_rd: got rd=%0h inc=%0h want 1/1", mem_rd, reg_pc_inc); end
    n_cmp++; if (reg_write !== 5'd7 || reg_write_op !== 2'b01 || reg_in_sel !== 2'b00) begin n_bad++; $display("FAIL ldn_operand_wr: got w=%0d op=%0h sel=%0h want 7/1/0", reg_write, reg_write_op, reg_in_sel); end
    n_cmp++; if (mem_rdata !== 8'h5A) begin n_bad++; $display("FAIL ldn_operand_data: got %0h want 5a", mem_rdata); end
    cyc(1'b1);
    n_cmp++; if (reg_pc !== 16'h0002 || reg_write_op !== 2'b00 || mem_rd !== 1'b1) begin n_bad++; $display("FAIL ldn_next_fetch: got pc=%0h op=%0h rd=%0h want 2/0/1", reg_pc, reg_write_op, mem_rd); end
  endtask

  task automatic test_ld_rr;
    restart(8'h41, 8'h00);
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b1);
    n_cmp++; if (reg_read_1 !== 5'd1 || reg_write !== 5'd0) begin n_bad++; $display("FAIL ldrr_sel: got r1=%0d w=%0d want 1/0", reg_read_1, reg_write); end
    n_cmp++; if (reg_in_sel !== 2'b01 || reg_write_op !== 2'b01) begin n_bad++; $display("FAIL ldrr_op: got sel=%0h op=%0h want 1/1", reg_in_sel, reg_write_op); end
    n_cmp++; if (reg_flags_write_en !== 8'h00 || mem_rd !== 1'b0 || reg_pc_inc !== 1'b0) begin n_bad++; $display("FAIL ldrr_quiet: got fwe=%0h rd=%0h inc=%0h want 0/0/0", reg_flags_write_en, mem_rd, reg_pc_inc); end
    cyc(1'b1);
    n_cmp++; if (mem_rd !== 1'b1 || reg_write_op !== 2'b00) begin n_bad++; $display("FAIL ldrr_next: got rd=%0h op=%0h want 1/0", mem_rd, reg_write_op); end
  endtask

  task automatic test_alu;
    restart(8'h80, 8'hB8);
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b1);
    n_cmp++; if (alu_op !== 3'd0 || reg_read_1 !== 5'd7 || reg_read_2 !== 5'd0) begin n_bad++; $display("FAIL add_sel: got op=%0d r1=%0d r2=%0d want 0/7/0", alu_op, reg_read_1, reg_read_2); end
    n_cmp++; if (reg_flags_write_en !== 8'hD7 || reg_in_sel !== 2'b10) begin n_bad++; $display("FAIL add_flags: got fwe=%0h sel=%0h want d7/2", reg_flags_write_en, reg_in_sel); end
    n_cmp++; if (reg_write !== 5'd7 || reg_write_op !== 2'b01) begin n_bad++; $display("FAIL add_write: got w=%0d op=%0h want 7/1", reg_write, reg_write_op); end
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b1);
    n_cmp++; if (alu_op !== 3'd7 || reg_read_2 !== 5'd0 || reg_flags_write_en !== 8'hD7) begin n_bad++; $display("FAIL cp_sel: got op=%0d r2=%0d fwe=%0h want 7/0/d7", alu_op, reg_read_2, reg_flags_write_en); end
    n_cmp++; if (reg_write_op !== 2'b00) begin n_bad++; $display("FAIL cp_nowrite: got %0h want 0", reg_write_op); end
  endtask

  task automatic test_halt_wait;
    restart(8'h76, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0);
      n_cmp++; if (mem_rd !== 1'b1 || reg_pc_inc !== 1'b0) begin n_bad++; $display("FAIL wait_fetch%0d: got rd=%0h inc=%0h want 1/0", i, mem_rd, reg_pc_inc); end
    end
    cyc(1'b1);
    n_cmp++; if (reg_pc_inc !== 1'b1 || reg_pc !== 16'h0000) begin n_bad++; $display("FAIL wait_release: got inc=%0h pc=%0h want 1/0", reg_pc_inc, reg_pc); end
    cyc(1'b1);
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_decode: got %0h want 0", halted); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1);
      n_cmp++; if (halted !== 1'b1 || mem_rd !== 1'b0 || reg_pc_inc !== 1'b0) begin n_bad++; $display("FAIL halt_hold%0d: got h=%0h rd=%0h inc=%0h want 1/0/0", i, halted, mem_rd, reg_pc_inc); end
    end
    restart(8'h00, 8'h00);
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_exit: got %0h want 0", halted); end
    cyc(1'b1);
    n_cmp++; if (mem_rd !== 1'b1) begin n_bad++; $display("FAIL halt_resume: got %0h want 1", mem_rd); end
  endtask

  task automatic test_illegal_abort;
    restart(8'h46, 8'h00);
    cyc(1'b1);
    n_cmp++; if (illegal_op !== 1'b0) begin n_bad++; $display("FAIL ill_fetch: got %0h want 0", illegal_op); end
    cyc(1'b1);
    n_cmp++; if (illegal_op !== 1'b1 || reg_write_op !== 2'b00) begin n_bad++; $display("FAIL ill_decode: got ill=%0h op=%0h want 1/0", illegal_op, reg_write_op); end
    cyc(1'b1);
    n_cmp++; if (illegal_op !== 1'b0 || mem_rd !== 1'b1 || reg_write_op !== 2'b00) begin n_bad++; $display("FAIL ill_next: got ill=%0h rd=%0h op=%0h want 0/1/0", illegal_op, mem_rd, reg_write_op); end
    restart(8'h3E, 8'h00);
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b0);
    n_cmp++; if (mem_rd !== 1'b1 || reg_write_op !== 2'b00 || reg_pc_inc !== 1'b0) begin n_bad++; $display("FAIL opnd_wait: got rd=%0h op=%0h inc=%0h want 1/0/0", mem_rd, reg_write_op, reg_pc_inc); end
    reset     = 1'b0;
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (mem_rd !== 1'b0 || reg_write_op !== 2'b00 || reg_write !== 5'd30 || reg_pc_inc !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got rd=%0h op=%0h w=%0d inc=%0h want 0/0/30/0", mem_rd, reg_write_op, reg_write, reg_pc_inc); end
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL abort_rst_cycle: got %0h want 0", mem_rd); end
    cyc(1'b1);
    n_cmp++; if (mem_rd !== 1'b1 || reg_pc !== 16'h0000) begin n_bad++; $display("FAIL abort_refetch: got rd=%0h pc=%0h want 1/0", mem_rd, reg_pc); end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset();
    test_ld_imm();
    test_ld_rr();
    test_alu();
    test_halt_wait();
    test_illegal_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Fetch/decode/execute controller for the 8-bit CPU core.
- Fetches opcodes and immediates over a simple memory read handshake and decodes a subset of the instruction set:
  - NOP
  - LD r,r'
  - LD r,n
  - 8-bit ALU A,r
  - HALT
- Drives the register file's read selects, write select, write op, flag write enables and PC increment. Drives the ALU op select and the register-input source mux.

Parameters:
- ALU_FLAGS_WE, 8'hD7, flag write-enable mask for ALU ops (S,Z,H,PV,N,C = bits 7,6,4,2,1,0).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- reg_pc  in  16  current PC from register file
- mem_addr  out  16  read address; equals reg_pc
- mem_rd  out  1  read request; held until mem_ready
- mem_ready  in  1  read data valid this cycle
- mem_rdata  in  8  read data
- reg_read_1  out  5  register file read select 1
- reg_read_2  out  5  register file read select 2
- reg_write  out  5  register file write select
- reg_write_op  out  2  00 IDLE, 01 WRITE, 10 EX, 11 LOAD
- reg_flags_write_en  out  8  per-bit flag write enables
- reg_pc_inc  out  1  PC increment strobe
- reg_in_sel  out  2  register-input mux: 00 mem_rdata, 01 reg_out_1, 10 alu_result
- alu_op  out  3  ALU op = opcode[5:3] (ADD,ADC,SUB,SBC,AND,XOR,OR,CP)
- halted  out  1  core is in HALT
- illegal_op  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- Register index mapping: r field ddd/sss maps to index {2'b00,r} for r≠110.
- States: RST, FETCH, DECODE, OPERAND, EXEC, HALT. Outputs are a decode of the state plus the instruction register ir.
- Default (idle) output values apply in every state unless overridden:
  - mem_rd=0, reg_write_op=IDLE, reg_write=NULL, reg_read_1/2=NULL
  - reg_flags_write_en=0, reg_pc_inc=0, reg_in_sel=00, alu_op=0
  - illegal_op=0, halted=0
- Reset: state=RST, ir=8'h00, all outputs at their idle values. RST moves to FETCH unconditionally on the next clk. Reset mid-instruction aborts it with no partial write.
- FETCH: mem_rd=1.
  - mem_ready=0: hold; no PC increment.
  - mem_ready=1: ir<=mem_rdata, reg_pc_inc=1, go to DECODE.
- DECODE (one cycle, no strobes):
  - 00 (NOP) -> FETCH.
  - 76 (HALT) -> HALT.
  - 01dddsss (d,s≠110) -> EXEC.
  - 00ddd110 (d≠110) -> OPERAND.
  - 10ooosss (s≠110) -> EXEC.
  - Anything else, including (HL) forms: illegal_op=1 for that cycle, then FETCH (treated as NOP).
- OPERAND: mem_rd=1, wait on mem_ready. On mem_ready=1, in the same cycle:
  - reg_write=ddd, reg_write_op=WRITE, reg_in_sel=00, reg_pc_inc=1
  - go to FETCH.
- EXEC for LD r,r':
  - reg_read_1=sss, reg_in_sel=01, reg_write=ddd, reg_write_op=WRITE
  - go to FETCH.
  - LD r,r (same register) is a legal write of itself.
- EXEC for ALU:
  - reg_read_1=A, reg_read_2=sss, alu_op=ooo, reg_in_sel=10, reg_flags_write_en=ALU_FLAGS_WE
  - reg_write=A, reg_write_op=WRITE, except CP (ooo=111): reg_write_op=IDLE, flags only
  - go to FETCH.
- HALT: halted=1 and no memory reads. Exit only by reset.
- Latency with mem_ready tied high: NOP 2 cycles; LD r,r', LD r,n and ALU 3 cycles each.
- Each wait cycle with mem_ready=0 adds one cycle.
- PC wraps FFFF->0000; this is handled in the register file.
- EX and LOAD write ops are never issued in this revision.

Decomposition:
- Shared package (extend the existing register-index constants include):
  - register indices: B..A = 0..7 (F=6), PCH=16, PCL=17, NULL=30, ONE=31
  - write-op codes IDLE/WRITE/EX/LOAD
  - reg_in_sel codes
  - ALU op codes
  - state encoding
- One sub-module, cpu_decode: purely combinational, ir -> {class, dst, src, alu_op, illegal}. The FSM stays in cpu_sequencer.

Test Plan:
- Release reset, memory returns 00 at 0000, mem_ready=1 -> RST, FETCH, DECODE, FETCH. mem_rd high in each FETCH. reg_pc_inc pulses once per FETCH. No reg_write_op≠IDLE.
- Opcode 3E then 5A, mem_ready=1 (LD A,5A) -> in OPERAND cycle: reg_write=7, reg_write_op=01, reg_in_sel=00, reg_pc_inc=1. Two PC increments in total.
- Opcode 41 (LD B,C) -> in EXEC: reg_read_1=1, reg_write=0, reg_in_sel=01, reg_write_op=01, flags_we=00.
- Opcode 80 (ADD A,B), then opcode B8 (CP B):
  - ADD: alu_op=0, reg_read_1=7, reg_read_2=0, flags_we=D7, reg_write=7, reg_write_op=01.
  - CP: alu_op=7, flags_we=D7, reg_write_op=00.
- mem_ready held low 3 cycles in FETCH, then opcode 76 -> mem_rd held high 3 cycles with no reg_pc_inc. After ready: halted=1 and mem_rd=0 forever. Reset deasserted again -> resumes fetching.
- Opcode 46 (LD B,(HL)) -> illegal_op=1 for exactly one cycle, no write, next FETCH. Reset asserted during OPERAND wait -> all strobes 0 immediately; restart from RST.
